// File: rtl/mdu_pipe_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states,
// counter width and small op-decode helpers.
package mdu_pipe_pkg;

  localparam int CNT_W = 5;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } mdu_state_e;

  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_mult(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

endpackage

// File: rtl/mdu_pipe_if.sv
// Issue/result bundle between the E stage (master) and the MDU (slave).
interface mdu_pipe_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath producing the full HI/LO result
// for MULT, MULTU, DIV and DIVU; other ops yield zero.
module mdu_arith
  import mdu_pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   q_mag;
  logic [WIDTH-1:0]   r_mag;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  always_comb begin
    prod   = '0;
    mag_a  = a[WIDTH-1] ? -a : a;
    mag_b  = b[WIDTH-1] ? -b : b;
    q_mag  = '0;
    r_mag  = '0;
    res_hi = '0;
    res_lo = '0;
    case (op)
      OP_MULT: begin
        prod   = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
      end
      OP_MULTU: begin
        prod   = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
      end
      OP_DIV: begin
        if (b == '0) begin
          res_lo = '1;
          res_hi = a;
        end else if ((a == MOST_NEG) && (b == '1)) begin
          res_lo = a;
          res_hi = '0;
        end else begin
          // Divide magnitudes, then restore signs: quotient truncates toward
          // zero and the remainder follows the dividend.
          q_mag  = mag_a / mag_b;
          r_mag  = mag_a % mag_b;
          res_lo = (a[WIDTH-1] ^ b[WIDTH-1]) ? -q_mag : q_mag;
          res_hi = a[WIDTH-1] ? -r_mag : r_mag;
        end
      end
      OP_DIVU: begin
        if (b == '0) begin
          res_lo = '1;
          res_hi = a;
        end else begin
          res_lo = a / b;
          res_hi = a % b;
        end
      end
      default: begin
        res_hi = '0;
        res_lo = '0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_pipe.sv
// Multi-cycle MIPS-style HI/LO unit: results are captured at issue and
// committed to HI/LO after a fixed per-op busy period.
module mdu_pipe
  import mdu_pipe_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  mdu_pipe_if.slave   bus
);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d;
  logic [WIDTH-1:0] pend_lo_q, pend_lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             last_cycle;

  mdu_arith #(.WIDTH(WIDTH)) u_arith (
    .op     (bus.op),
    .a      (bus.a),
    .b      (bus.b),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  assign last_cycle = (state_q == S_BUSY) && (cnt_q == CNT_W'(1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (is_arith(bus.op)) begin
            pend_hi_d = res_hi;
            pend_lo_d = res_lo;
            cnt_d     = is_mult(bus.op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            state_d   = S_BUSY;
          end else if (bus.op == OP_MTHI) begin
            hi_d = bus.a;
          end else if (bus.op == OP_MTLO) begin
            lo_d = bus.a;
          end
        end
      end
      S_BUSY: begin
        // Any start seen here, including one in the done cycle, is dropped.
        if (last_cycle) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign bus.busy = (state_q == S_BUSY);
  assign bus.done = last_cycle && !reset;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
